// File: rtl/imem_loader.sv
// Boot-time image loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until the load completes.
module imem_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_cnt;
    logic [31:0]       r_shift;
    logic [31:0]       r_n;
    logic [31:0]       r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wd;

    logic              w_ready;
    logic              w_xfer;
    logic              w_lastByte;
    logic              w_startOk;
    logic [31:0]       w_shift;

    // A reset cycle must not accept a byte or issue a write, so gate both with reset.
    assign in_ready   = w_ready & ~reset;
    assign w_xfer     = in_valid & in_ready;
    assign w_lastByte = w_xfer & (r_cnt == 2'd3);
    assign w_shift    = {r_shift[23:0], in_data};
    assign w_startOk  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));

    assign mem_we    = (r_state == S_WRITE) & ~reset;
    assign mem_addr  = r_addr;
    assign mem_wd    = r_wd;
    assign busy      = (r_state == S_HDR) | (r_state == S_DATA) | (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign cpu_reset = (r_state != S_DONE);

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR;
            end
            S_HDR: begin
                w_ready = 1'b1;
                if (w_lastByte) begin
                    if (w_shift == 32'd0)     w_next = S_DONE;
                    else if (w_shift > DEPTH) w_next = S_ERR;
                    else                      w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (w_lastByte) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (r_idx == r_n - 32'd1) w_next = S_DONE;
                else                      w_next = S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) w_next = S_HDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_shift <= 32'd0;
            r_n     <= 32'd0;
            r_idx   <= 32'd0;
            r_addr  <= '0;
            r_wd    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_cnt   <= r_cnt + 2'd1;
                r_shift <= w_shift;
            end
            if (w_startOk) begin
                r_cnt <= 2'd0;
            end
            if ((r_state == S_HDR) && w_lastByte) begin
                r_n   <= w_shift;
                r_idx <= 32'd0;
            end
            // Address and data are captured once per word so they stay stable around the pulse.
            if ((r_state == S_DATA) && w_lastByte) begin
                r_addr <= r_idx[ADDR_W-1:0];
                r_wd   <= w_shift;
            end
            if ((r_state == S_WRITE) && (w_next == S_DATA)) begin
                r_idx <= r_idx + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams compared
// against a stream-parsing reference model of the expected memory writes.
module tb_imem_loader;

    localparam int ADDR_W = 14;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_reset;

    int checks = 0;
    int failures = 0;

    logic [31:0] obsAddr[$];
    logic [31:0] obsWd[$];
    logic [31:0] expAddr[$];
    logic [31:0] expWd[$];
    logic [7:0]  stream[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
        .busy(busy), .done(done), .err(err), .cpu_reset(cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Capture every write pulse; the loader must never offer ready while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obsAddr.push_back(32'(mem_addr));
            obsWd.push_back(mem_wd);
            checkOutput("in_ready_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    // Reference model: parse the stream into the list of (address, word) writes it implies.
    function automatic logic [31:0] headerOf(input logic [7:0] s[$]);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    task automatic buildExpected(input logic [7:0] s[$]);
        logic [31:0] n;
        expAddr.delete();
        expWd.delete();
        n = headerOf(s);
        if (n != 0 && n <= DEPTH) begin
            for (int k = 0; k < int'(n); k++) begin
                expAddr.push_back(32'(k));
                expWd.push_back({s[4+4*k], s[5+4*k], s[6+4*k], s[7+4*k]});
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulseReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapMax);
        logic rdy;
        int budget;
        if (gapMax > 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(gapMax, 0)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        budget = 0;
        rdy = 1'b0;
        while (!rdy && budget < 500) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            budget++;
        end
        if (!rdy) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] s[$], input int first, input int count, input int gapMax);
        for (int i = first; i < first + count; i++) sendByte(s[i], gapMax);
        in_valid = 1'b0;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_count"}, 32'(obsWd.size()), 32'(expWd.size()));
        for (int i = 0; i < expWd.size() && i < obsWd.size(); i++) begin
            checkOutput({tag, "_addr"}, obsAddr[i], expAddr[i]);
            checkOutput({tag, "_wd"}, obsWd[i], expWd[i]);
        end
    endtask

    task automatic runLoad(input string tag, input logic [7:0] s[$], input int gapMax);
        logic [31:0] n;
        buildExpected(s);
        obsAddr.delete();
        obsWd.delete();
        pulseStart();
        applyStimulus(s, 0, s.size(), gapMax);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkWrites(tag);
        n = headerOf(s);
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, n <= DEPTH});
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, n > DEPTH});
        checkOutput({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, n > DEPTH});
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic randomImage(input int words);
        stream.delete();
        stream.push_back(8'd0); stream.push_back(8'd0);
        stream.push_back(8'd0); stream.push_back(8'(words));
        for (int i = 0; i < 4 * words; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        int budget;
        logic [7:0] s[$];

        // Reset state
        pulseReset(2);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        @(posedge clk); #1;

        // Two-word image back-to-back, then with random valid gaps
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hde, 8'had, 8'hbe, 8'haf, 8'h00, 8'h2f, 8'h01, 8'h23};
        runLoad("two_words", s, 0);
        checkOutput("two_words_wd0_const", obsWd.size() > 0 ? obsWd[0] : 32'hx, 32'hdeadbeaf);
        runLoad("two_words_gaps", s, 3);

        // Empty image
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        runLoad("empty", s, 0);

        // Oversized header, then recovery with a one-word image
        s = '{8'h00, 8'h00, 8'h40, 8'h01};
        runLoad("oversize", s, 1);
        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        runLoad("after_err", s, 0);

        // Header of exactly DEPTH words is legal: loader must enter data phase
        obsWd.delete();
        pulseStart();
        s = '{8'h00, 8'h00, 8'h40, 8'h00};
        applyStimulus(s, 0, 4, 0);
        @(negedge clk);
        checkOutput("depth_busy", {31'd0, busy}, 32'd1);
        checkOutput("depth_err", {31'd0, err}, 32'd0);
        checkOutput("depth_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        pulseReset(1);

        // Reset mid-load after the second write, then a full reload
        randomImage(3);
        s = stream;
        buildExpected(s);
        obsAddr.delete();
        obsWd.delete();
        pulseStart();
        applyStimulus(s, 0, 12, 0);
        budget = 0;
        while (obsWd.size() < 2 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("midrst_two_writes", 32'(obsWd.size()), 32'd2);
        applyStimulus(s, 12, 2, 0);
        pulseReset(1);
        @(negedge clk);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_third", 32'(obsWd.size()), 32'd2);
        @(posedge clk); #1;
        runLoad("reload", s, 2);

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        @(posedge clk); #1;

        // Randomized images
        for (int t = 0; t < 6; t++) begin
            randomImage($urandom_range(6, 1));
            runLoad("random", stream, $urandom_range(3, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
